// File: rtl/video_fetch.sv
// video_fetch: raster timing generator and bitplane fetch from the video RAM read port,
// serialising up to three planes MSB-first into registered 1-bit R/G/B with sync and blank.
module video_fetch #(
    parameter int AW       = 15,
    parameter int PLANES   = 3,
    parameter int PLANE_SH = 13,
    parameter int H_ACT    = 256,
    parameter int H_TOTAL  = 448,
    parameter int HS_START = 320,
    parameter int HS_END   = 352,
    parameter int V_ACT    = 248,
    parameter int V_TOTAL  = 312,
    parameter int VS_START = 272,
    parameter int VS_END   = 275
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce_pix,
    output logic          ce1,
    output logic [AW-1:0] a1,
    input  logic [7:0]    do1,
    output logic          r,
    output logic          g,
    output logic          b,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic          frame
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;

    logic          h_last;
    logic          v_last;
    logic          line_act;
    logic          fetch_grp;
    logic          fetch_slot;
    logic          load;
    logic          window;
    logic          hs_win;
    logic          vs_win;
    logic [2:0]    k;
    logic [AW-1:0] addr;

    logic          cap_valid;
    logic [1:0]    cap_k;
    logic [7:0]    hold  [3];
    logic [7:0]    shift [3];

    always_comb begin
        h_last     = (hcount == HW'(H_TOTAL - 1));
        v_last     = (vcount == VW'(V_TOTAL - 1));
        line_act   = (vcount < VW'(V_ACT));
        fetch_grp  = line_act && (hcount < HW'(H_ACT));
        k          = hcount[2:0];
        fetch_slot = (32'(k) < 32'(PLANES));
        load       = fetch_grp && (k == 3'd7);
        window     = line_act && (hcount >= HW'(8)) && (hcount < HW'(H_ACT + 8));
        hs_win     = (hcount >= HW'(HS_START)) && (hcount < HW'(HS_END));
        vs_win     = (vcount >= VW'(VS_START)) && (vcount < VW'(VS_END));
        addr       = AW'(32'(k) << PLANE_SH)
                   + AW'(32'(vcount) * 32'(H_ACT / 8))
                   + AW'(hcount >> 3);
    end

    // The read strobe is gated by ce_pix so it is one clock wide at any pixel cadence.
    always_comb begin
        ce1 = ce_pix && fetch_grp && fetch_slot && !reset;
        a1  = ce1 ? addr : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (ce_pix) begin
            if (h_last) begin
                hcount <= '0;
                vcount <= v_last ? '0 : vcount + VW'(1);
            end else begin
                hcount <= hcount + HW'(1);
            end
        end
    end

    // RAM data arrives one clock after the strobe; the plane index travels with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_valid <= 1'b0;
            cap_k     <= '0;
            for (int unsigned p = 0; p < 3; p++) begin
                hold[p] <= '0;
            end
        end else begin
            cap_valid <= ce1;
            cap_k     <= k[1:0];
            for (int unsigned p = 0; p < 3; p++) begin
                if (cap_valid && (cap_k == 2'(p))) begin
                    hold[p] <= do1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned p = 0; p < 3; p++) begin
                shift[p] <= '0;
            end
        end else if (ce_pix) begin
            for (int unsigned p = 0; p < 3; p++) begin
                if (load) begin
                    shift[p] <= (p < 32'(PLANES)) ? hold[p] : '0;
                end else begin
                    shift[p] <= {shift[p][6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r     <= 1'b0;
            g     <= 1'b0;
            b     <= 1'b0;
            hsync <= 1'b0;
            vsync <= 1'b0;
            blank <= 1'b1;
            frame <= 1'b0;
        end else begin
            frame <= ce_pix && h_last && v_last;
            if (ce_pix) begin
                r     <= window && shift[0][7];
                g     <= window && shift[1][7];
                b     <= window && shift[2][7];
                blank <= !window;
                hsync <= hs_win;
                vsync <= vs_win;
            end
        end
    end

endmodule

// File: tb/tb_video_fetch.sv
// Bench for video_fetch: RAM model plus a pixel-level raster reference computed from frame coordinates.
module tb_video_fetch;

    localparam int AW       = 15;
    localparam int PLANES   = 3;
    localparam int PLANE_SH = 13;
    localparam int H_ACT    = 256;
    localparam int H_TOTAL  = 448;
    localparam int HS_START = 320;
    localparam int HS_END   = 352;
    // Short frame so a whole frame fits in a reasonable run.
    localparam int V_ACT    = 44;
    localparam int V_TOTAL  = 48;
    localparam int VS_START = 45;
    localparam int VS_END   = 47;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ce_pix = 1'b0;
    logic          ce1;
    logic [AW-1:0] a1;
    logic [7:0]    do1 = 8'h00;
    logic          r, g, b, hsync, vsync, blank, frame;

    always #5 clock = ~clock;

    video_fetch #(
        .AW(AW), .PLANES(PLANES), .PLANE_SH(PLANE_SH),
        .H_ACT(H_ACT), .H_TOTAL(H_TOTAL), .HS_START(HS_START), .HS_END(HS_END),
        .V_ACT(V_ACT), .V_TOTAL(V_TOTAL), .VS_START(VS_START), .VS_END(VS_END)
    ) dut (
        .clock(clock), .reset(reset), .ce_pix(ce_pix),
        .ce1(ce1), .a1(a1), .do1(do1),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .blank(blank), .frame(frame)
    );

    logic [7:0] mem [32768];
    always @(posedge clock) if (ce1) do1 <= mem[a1];

    int checks = 0;
    int errors = 0;

    int mh = 0, mv = 0;
    int sh, sv;
    bit scp;
    logic s_ce1;
    logic [AW-1:0] s_a1;
    bit e_ce1;
    int e_a1;
    bit e_r, e_g, e_b, e_hs, e_vs, e_frame;
    bit e_blank = 1'b1;
    logic [3:0] stream [H_TOTAL];

    function automatic bit fetch_at(int h, int v);
        return (v < V_ACT) && (h < H_ACT) && ((h % 8) < PLANES);
    endfunction

    function automatic int addr_at(int h, int v);
        return (((h % 8) << PLANE_SH) + v * (H_ACT / 8) + h / 8) % (1 << AW);
    endfunction

    function automatic bit pix(int p, int x, int y);
        logic [7:0] d;
        if (p >= PLANES) return 1'b0;
        d = mem[(p << PLANE_SH) + y * (H_ACT / 8) + x / 8];
        return d[7 - (x % 8)];
    endfunction

    // One clock: drive inputs, snapshot the combinational read port, then advance the reference.
    task automatic tick(input bit cp, input bit rst);
        bit win;
        @(negedge clock);
        ce_pix = cp;
        reset  = rst;
        #2;
        sh = mh; sv = mv; scp = cp;
        s_ce1 = ce1; s_a1 = a1;
        e_ce1 = !rst && cp && fetch_at(mh, mv);
        e_a1  = addr_at(mh, mv);
        @(posedge clock);
        #1;
        if (rst) begin
            mh = 0; mv = 0;
            {e_r, e_g, e_b, e_hs, e_vs, e_frame} = '0;
            e_blank = 1'b1;
        end else begin
            e_frame = cp && (sh == H_TOTAL - 1) && (sv == V_TOTAL - 1);
            if (cp) begin
                win     = (sv < V_ACT) && (sh >= 8) && (sh < H_ACT + 8);
                e_blank = !win;
                e_r     = win && pix(0, sh - 8, sv);
                e_g     = win && pix(1, sh - 8, sv);
                e_b     = win && pix(2, sh - 8, sv);
                e_hs    = (sh >= HS_START) && (sh < HS_END);
                e_vs    = (sv >= VS_START) && (sv < VS_END);
                if (mh == H_TOTAL - 1) begin
                    mh = 0;
                    mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        repeat (3) begin
            tick(1'b1, 1'b1);
            checks++;
            if ({s_ce1, r, g, b, hsync, vsync, blank, frame} !== 8'b0_0000010) begin
                errors++;
                $display("FAIL reset_outputs: got %b expected %b", {s_ce1, r, g, b, hsync, vsync, blank, frame}, 8'b0_0000010);
            end
        end
        for (int h = 0; h < 4; h++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (s_ce1 !== (h < 3) || (h < 3 && s_a1 !== AW'(h << PLANE_SH))) begin
                errors++;
                $display("FAIL reset_restart h=%0d: got ce1=%b a1=%h expected ce1=%b a1=%h", h, s_ce1, s_a1, h < 3, AW'(h << PLANE_SH));
            end
        end
    endtask

    task automatic test_fetch_addr();
        while (!(mv == 1 && mh == 1)) begin
            tick(1'b1, 1'b0);
            checks++;
            if (s_ce1 !== e_ce1 || (e_ce1 && s_a1 !== AW'(e_a1))) begin
                errors++;
                $display("FAIL fetch_addr h=%0d v=%0d: got ce1=%b a1=%h expected ce1=%b a1=%h", sh, sv, s_ce1, s_a1, e_ce1, AW'(e_a1));
            end
            if (sh == 8 && sv == 0) begin
                checks++;
                if (s_ce1 !== 1'b1 || s_a1 !== 15'h0001) begin
                    errors++;
                    $display("FAIL fetch_h8: got ce1=%b a1=%h expected ce1=1 a1=0001", s_ce1, s_a1);
                end
            end
            if (sh == 0 && sv == 1) begin
                checks++;
                if (s_ce1 !== 1'b1 || s_a1 !== 15'h0020) begin
                    errors++;
                    $display("FAIL fetch_line1: got ce1=%b a1=%h expected ce1=1 a1=0020", s_ce1, s_a1);
                end
            end
        end
    endtask

    task automatic test_pattern_a5();
        logic [7:0] bits;
        bits = '0;
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5;
        tick(1'b1, 1'b1);
        for (int n = 0; n < H_TOTAL; n++) begin
            tick(1'b1, 1'b0);
            checks++;
            if ({r, g, b, hsync, vsync, blank, frame} !== {e_r, e_g, e_b, e_hs, e_vs, e_blank, e_frame}) begin
                errors++;
                $display("FAIL a5_pixels h=%0d: got %b expected %b", sh, {r, g, b, hsync, vsync, blank, frame}, {e_r, e_g, e_b, e_hs, e_vs, e_blank, e_frame});
            end
            stream[sh] = {r, g, b, blank};
            if (sh >= 8 && sh < 16) bits[15 - sh] = r;
        end
        checks++;
        if (bits !== 8'hA5) begin
            errors++;
            $display("FAIL a5_red_x0to7: got %b expected 10100101", bits);
        end
        checks++;
        if (stream[7][0] !== 1'b1 || stream[8][0] !== 1'b0 || stream[15][2:1] !== 2'b00) begin
            errors++;
            $display("FAIL a5_blank_gb: got h7=%b h8=%b h15=%b expected blank 1 then 0, g=b=0", stream[7], stream[8], stream[15]);
        end
    endtask

    task automatic test_sparse();
        tick(1'b1, 1'b1);
        for (int i = 0; i < 3 * H_TOTAL; i++) begin
            tick((i % 3) == 2, 1'b0);
            checks++;
            if (s_ce1 !== e_ce1 || (e_ce1 && s_a1 !== AW'(e_a1))) begin
                errors++;
                $display("FAIL sparse_ce1 h=%0d cp=%b: got ce1=%b a1=%h expected ce1=%b a1=%h", sh, scp, s_ce1, s_a1, e_ce1, AW'(e_a1));
            end
            checks++;
            if ({r, g, b, hsync, vsync, blank, frame} !== {e_r, e_g, e_b, e_hs, e_vs, e_blank, e_frame}
                || (scp && {r, g, b, blank} !== stream[sh])) begin
                errors++;
                $display("FAIL sparse_pixels h=%0d: got %b expected %b dense %b", sh, {r, g, b, hsync, vsync, blank, frame}, {e_r, e_g, e_b, e_hs, e_vs, e_blank, e_frame}, stream[sh]);
            end
        end
    endtask

    task automatic test_random_frame();
        int pulses = 0, pulse_at = 0, hs_cnt = 0, vs_cnt = 0, late_fetch = 0;
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        tick(1'b1, 1'b1);
        for (int n = 1; n <= H_TOTAL * V_TOTAL; n++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (s_ce1 !== e_ce1 || (e_ce1 && s_a1 !== AW'(e_a1))
                || {r, g, b, hsync, vsync, blank, frame} !== {e_r, e_g, e_b, e_hs, e_vs, e_blank, e_frame}) begin
                errors++;
                $display("FAIL frame_raster h=%0d v=%0d: got ce1=%b a1=%h out=%b expected ce1=%b a1=%h out=%b", sh, sv, s_ce1, s_a1, {r, g, b, hsync, vsync, blank, frame}, e_ce1, AW'(e_a1), {e_r, e_g, e_b, e_hs, e_vs, e_blank, e_frame});
            end
            if (frame === 1'b1) begin pulses++; pulse_at = n; end
            if (hsync === 1'b1 && sv == 0) hs_cnt++;
            if (vsync === 1'b1) vs_cnt++;
            if (s_ce1 === 1'b1 && sv >= V_ACT) late_fetch++;
        end
        checks++;
        if (pulses != 1 || pulse_at != H_TOTAL * V_TOTAL) begin
            errors++;
            $display("FAIL frame_pulse: got %0d pulses at %0d expected 1 at %0d", pulses, pulse_at, H_TOTAL * V_TOTAL);
        end
        checks++;
        if (hs_cnt != HS_END - HS_START || vs_cnt != (VS_END - VS_START) * H_TOTAL) begin
            errors++;
            $display("FAIL sync_width: got hs=%0d vs=%0d expected hs=%0d vs=%0d", hs_cnt, vs_cnt, HS_END - HS_START, (VS_END - VS_START) * H_TOTAL);
        end
        checks++;
        if (late_fetch != 0) begin
            errors++;
            $display("FAIL no_fetch_inactive: got %0d strobes expected 0", late_fetch);
        end
    endtask

    task automatic test_reset_midline();
        while (!(mv == 40 && mh == 130)) begin
            tick(1'b1, 1'b0);
            checks++;
            if (s_ce1 !== e_ce1 || {r, g, b, hsync, vsync, blank, frame} !== {e_r, e_g, e_b, e_hs, e_vs, e_blank, e_frame}) begin
                errors++;
                $display("FAIL midline_run h=%0d v=%0d: got ce1=%b out=%b expected ce1=%b out=%b", sh, sv, s_ce1, {r, g, b, hsync, vsync, blank, frame}, e_ce1, {e_r, e_g, e_b, e_hs, e_vs, e_blank, e_frame});
            end
        end
        tick(1'b1, 1'b1);
        checks++;
        if ({s_ce1, r, g, b, hsync, vsync, blank, frame} !== 8'b0_0000010) begin
            errors++;
            $display("FAIL midline_reset: got %b expected %b", {s_ce1, r, g, b, hsync, vsync, blank, frame}, 8'b0_0000010);
        end
        for (int n = 0; n < 2 * H_TOTAL; n++) begin
            tick(1'b1, 1'b0);
            if (n == 0) begin
                checks++;
                if (s_ce1 !== 1'b1 || s_a1 !== 15'h0000) begin
                    errors++;
                    $display("FAIL midline_restart: got ce1=%b a1=%h expected ce1=1 a1=0000", s_ce1, s_a1);
                end
            end
            checks++;
            if (s_ce1 !== e_ce1 || (e_ce1 && s_a1 !== AW'(e_a1))
                || {r, g, b, hsync, vsync, blank, frame} !== {e_r, e_g, e_b, e_hs, e_vs, e_blank, e_frame}) begin
                errors++;
                $display("FAIL midline_after h=%0d v=%0d: got ce1=%b a1=%h out=%b expected ce1=%b a1=%h out=%b", sh, sv, s_ce1, s_a1, {r, g, b, hsync, vsync, blank, frame}, e_ce1, AW'(e_a1), {e_r, e_g, e_b, e_hs, e_vs, e_blank, e_frame});
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_addr();
        test_pattern_a5();
        test_sparse();
        test_random_frame();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
